meter_sweep_scheduler: RTL and testbench
========================================

Name: meter_sweep_scheduler

Overview:
- Sequences one shared gate/count datapath across NUM_CH sig_in channels for frequency and duty-cycle measurement.
- Selects a channel, waits for the mux to settle, clears the counters, opens a programmable gate window, latches the result, then hands the result to the readout logic over a valid/ready handshake.
- Supports single-sweep and continuous operation. Unselected channels are skipped round-robin.

Parameters:
- NUM_CH, 4, number of input channels sharing the datapath.
- CH_W, 2, width of the channel index; must satisfy 2**CH_W >= NUM_CH.
- GATE_W, 32, width of the gate-length counter and gate_len port.
- SETTLE_CYC, 10, cycles to wait after a channel switch before clearing the counters.

Ports:
- sys_clk  in  1  system clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a sweep when IDLE.
- continuous  in  1  when 1, a sweep restarts automatically after its last channel.
- abort  in  1  one-cycle pulse; terminates any operation.
- ch_mask  in  NUM_CH  channels to measure; bit i = channel i.
- gate_len  in  GATE_W  gate window length in sys_clk cycles.
- ch_sel  out  CH_W  datapath input mux select.
- cnt_clr  out  1  one-cycle counter clear.
- gate_en  out  1  count enable for the datapath.
- latch  out  1  one-cycle result capture strobe.
- res_valid  out  1  latched result available.
- res_ready  in  1  readout accepts the result.
- res_ch  out  CH_W  channel the current result belongs to.
- busy  out  1  high in every state except IDLE.
- cfg_err  out  1  one-cycle pulse; start was rejected.

Behaviour:
Clocking and reset:
- Single clock, sys_clk. Reset is synchronous and active-high on rst.
- Reset state is IDLE. All outputs reset to 0, including ch_sel and res_ch.
- All outputs are registered and decoded from the state register (Moore outputs).

Configuration sampling:
- ch_mask, gate_len and continuous are sampled into shadow registers on an accepted start.
- gate_len is resampled at the start of every continuous sweep. Changes mid-sweep have no effect.
- gate_len of 0 is treated as 1.

FSM states: IDLE, SETTLE, CLEAR, GATE, LATCH, REPORT.
- IDLE: start with ch_mask != 0 -> SETTLE; ch_sel becomes the lowest set bit of the mask.
- IDLE: start with ch_mask == 0 -> stay in IDLE and pulse cfg_err for 1 cycle.
- start in any state other than IDLE is ignored.
- SETTLE: lasts exactly SETTLE_CYC cycles -> CLEAR.
- CLEAR: cnt_clr = 1 for exactly 1 cycle -> GATE.
- GATE: gate_en = 1 for exactly gate_len cycles -> LATCH.
- LATCH: latch = 1 for 1 cycle -> REPORT. res_ch is loaded with ch_sel.
- REPORT: res_valid = 1 and is held, with res_ch stable, until res_ready = 1 is sampled. The transfer completes in that same cycle.
  - If another masked channel remains above the current one -> SETTLE with the next higher masked channel.
  - Otherwise, if continuous = 1 -> SETTLE with the lowest masked channel (wrap-around).
  - Otherwise -> IDLE.
- If the next channel equals the current one (single-bit mask), SETTLE is still entered.

Latency:
- Start accepted at cycle t: SETTLE occupies cycles t+1 .. t+SETTLE_CYC, CLEAR occupies cycle t+SETTLE_CYC+1, and GATE begins the cycle after.
- res_valid first rises at cycle t + SETTLE_CYC + gate_len + 3.

Backpressure:
- REPORT stalls indefinitely while res_ready = 0.
- No new gate opens until the pending result is accepted, so results are never dropped.

abort:
- In any state, abort -> IDLE on the next edge.
- gate_en, res_valid and busy drop on that edge. latch is not issued, and any pending result is discarded.
- abort has priority over start and res_ready in the same cycle.

Continuous mode:
- Clearing continuous mid-sweep has no effect; the shadow copy applies.
- To stop a continuous sweep, use abort.

Decomposition:
- Shared package meter_pkg: state encoding enum, SETTLE_CYC default, and a function returning the next set bit of a mask strictly above an index, with wrap-around.
- One natural sub-module: meter_rr_pick, a combinational round-robin next-channel picker that also flags "no higher channel" (end of sweep).
- Everything else lives in the top FSM together with its settle and gate down-counters.

Test Plan:
- NUM_CH=4, SETTLE_CYC=10, mask=4'b0101, gate_len=20, continuous=0, res_ready=1; start at t=0 -> expect:
  - ch_sel=0; cnt_clr at t=11; gate_en high t=12..31; latch at t=32; res_valid at t=33 with res_ch=0.
  - Then ch_sel=2 and a second result with res_ch=2.
  - Then IDLE with busy=0.
- mask=0, start -> cfg_err is a 1-cycle pulse, busy stays 0, no cnt_clr.
- res_ready held 0 for 50 cycles in REPORT -> res_valid and res_ch stay stable, gate_en stays 0 throughout; the next SETTLE begins the cycle after res_ready=1.
- continuous=1, mask=4'b1000, gate_len=0 -> every gate_en window is exactly 1 cycle; results repeat with res_ch=3 indefinitely, with SETTLE between each.
- abort during GATE at cycle 5 of a 20-cycle window -> gate_en drops on the next edge, latch never pulses, state is IDLE; a following start runs normally.
- start while busy, plus a gate_len change mid-sweep -> start is ignored and gate windows keep the sampled length; rst asserted mid-GATE -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/meter_pkg.sv
// Shared definitions for the meter sweep scheduler: FSM encoding, default
// settle time and a round-robin "next set bit" helper.
package meter_pkg;

    localparam int unsigned MAX_CH         = 32;
    localparam int unsigned SETTLE_CYC_DEF = 10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_CLEAR  = 3'd2,
        ST_GATE   = 3'd3,
        ST_LATCH  = 3'd4,
        ST_REPORT = 3'd5
    } state_e;

    // Next set bit strictly above idx, wrapping past n-1 back to 0.
    // Returns idx when the mask is empty; idx = n-1 yields the lowest set bit.
    function automatic int unsigned next_set_above(input logic [MAX_CH-1:0] mask,
                                                   input int unsigned idx,
                                                   input int unsigned n);
        int unsigned j;
        logic        found;
        next_set_above = idx;
        found          = 1'b0;
        for (int unsigned k = 1; k <= MAX_CH; k++) begin
            if (!found && k <= n) begin
                j = idx + k;
                if (j >= n) j = j - n;
                if (mask[j[4:0]]) begin
                    next_set_above = j;
                    found          = 1'b1;
                end
            end
        end
    endfunction

endpackage

// File: rtl/meter_rr_pick.sv
// Combinational round-robin channel picker: next masked channel above the
// current one, lowest masked channel, and an end-of-sweep flag.
module meter_rr_pick
    import meter_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
) (
    input  logic [NUM_CH-1:0] mask_i,
    input  logic [CH_W-1:0]   cur_i,
    output logic [CH_W-1:0]   next_ch_o,
    output logic [CH_W-1:0]   lowest_ch_o,
    output logic              last_o
);

    logic [MAX_CH-1:0] wide_mask;

    assign wide_mask   = MAX_CH'(mask_i);
    assign next_ch_o   = CH_W'(next_set_above(wide_mask, 32'(cur_i), NUM_CH));
    assign lowest_ch_o = CH_W'(next_set_above(wide_mask, NUM_CH - 1, NUM_CH));

    // last_o: no masked channel sits above the current one
    always_comb begin
        last_o = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (i > int'(cur_i) && mask_i[i]) last_o = 1'b0;
        end
    end

endmodule

// File: rtl/meter_sweep_scheduler.sv
// Sweeps a shared gate/count datapath over the masked channels: settle,
// clear, gate, latch, then hand the result off over valid/ready.
module meter_sweep_scheduler
    import meter_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int CH_W       = 2,
    parameter int GATE_W     = 32,
    parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              start,
    input  logic              continuous,
    input  logic              abort,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic [GATE_W-1:0] gate_len,
    output logic [CH_W-1:0]   ch_sel,
    output logic              cnt_clr,
    output logic              gate_en,
    output logic              latch,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [CH_W-1:0]   res_ch,
    output logic              busy,
    output logic              cfg_err
);

    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    state_e              state_q, state_d;
    logic [CH_W-1:0]     ch_sel_q, ch_sel_d;
    logic [CH_W-1:0]     res_ch_q, res_ch_d;
    logic [SET_W-1:0]    settle_q, settle_d;
    logic [GATE_W-1:0]   gate_q, gate_d;
    logic [GATE_W-1:0]   gate_len_q, gate_len_d;
    logic [NUM_CH-1:0]   mask_q, mask_d;
    logic                cont_q, cont_d;
    logic                cfg_err_q, cfg_err_d;

    logic [NUM_CH-1:0]   pick_mask;
    logic [CH_W-1:0]     next_ch, lowest_ch;
    logic                last_ch;

    function automatic logic [GATE_W-1:0] clamp_gate(input logic [GATE_W-1:0] len);
        return (len == '0) ? GATE_W'(1) : len;
    endfunction

    // In IDLE the picker sees the live mask so the first channel is ready at start.
    assign pick_mask = (state_q == ST_IDLE) ? ch_mask : mask_q;

    meter_rr_pick #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_pick (
        .mask_i      (pick_mask),
        .cur_i       (ch_sel_q),
        .next_ch_o   (next_ch),
        .lowest_ch_o (lowest_ch),
        .last_o      (last_ch)
    );

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ch_sel_q   <= '0;
            res_ch_q   <= '0;
            settle_q   <= '0;
            gate_q     <= '0;
            gate_len_q <= GATE_W'(1);
            mask_q     <= '0;
            cont_q     <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ch_sel_q   <= ch_sel_d;
            res_ch_q   <= res_ch_d;
            settle_q   <= settle_d;
            gate_q     <= gate_d;
            gate_len_q <= gate_len_d;
            mask_q     <= mask_d;
            cont_q     <= cont_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ch_sel_d   = ch_sel_q;
        res_ch_d   = res_ch_q;
        settle_d   = settle_q;
        gate_d     = gate_q;
        gate_len_d = gate_len_q;
        mask_d     = mask_q;
        cont_d     = cont_q;
        cfg_err_d  = 1'b0;

        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (ch_mask != '0) begin
                            state_d    = ST_SETTLE;
                            mask_d     = ch_mask;
                            cont_d     = continuous;
                            gate_len_d = clamp_gate(gate_len);
                            ch_sel_d   = lowest_ch;
                            settle_d   = SET_W'(SETTLE_CYC - 1);
                        end else begin
                            cfg_err_d = 1'b1;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (settle_q == '0) state_d = ST_CLEAR;
                    else                settle_d = settle_q - SET_W'(1);
                end
                ST_CLEAR: begin
                    state_d = ST_GATE;
                    gate_d  = gate_len_q - GATE_W'(1);
                end
                ST_GATE: begin
                    if (gate_q == '0) state_d = ST_LATCH;
                    else              gate_d  = gate_q - GATE_W'(1);
                end
                ST_LATCH: begin
                    state_d  = ST_REPORT;
                    res_ch_d = ch_sel_q;
                end
                ST_REPORT: begin
                    if (res_ready) begin
                        if (!last_ch) begin
                            state_d  = ST_SETTLE;
                            ch_sel_d = next_ch;
                            settle_d = SET_W'(SETTLE_CYC - 1);
                        end else if (cont_q) begin
                            // New continuous sweep: gate length is refreshed here only.
                            state_d    = ST_SETTLE;
                            ch_sel_d   = lowest_ch;
                            settle_d   = SET_W'(SETTLE_CYC - 1);
                            gate_len_d = clamp_gate(gate_len);
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign ch_sel    = ch_sel_q;
    assign res_ch    = res_ch_q;
    assign cnt_clr   = (state_q == ST_CLEAR);
    assign gate_en   = (state_q == ST_GATE);
    assign latch     = (state_q == ST_LATCH);
    assign res_valid = (state_q == ST_REPORT);
    assign busy      = (state_q != ST_IDLE);
    assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_meter_sweep_scheduler.sv
// Directed bench for meter_sweep_scheduler: a cycle-indexed vector table for
// the basic two-channel sweep plus hand-written multi-cycle corner cases.
module tb_meter_sweep_scheduler;

    logic        sys_clk = 1'b0;
    logic        rst, start, continuous, abort, res_ready;
    logic [3:0]  ch_mask;
    logic [31:0] gate_len;
    logic [1:0]  ch_sel, res_ch;
    logic        cnt_clr, gate_en, latch, res_valid, busy, cfg_err;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int         cyc;
        logic [1:0] ch;
        logic       clr, gate, lat, vld;
        logic [1:0] rch;
        logic       bsy;
    } vec_t;

    localparam int NV = 15;
    vec_t tbl [NV];

    always #5 sys_clk = ~sys_clk;

    meter_sweep_scheduler dut (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .start      (start),
        .continuous (continuous),
        .abort      (abort),
        .ch_mask    (ch_mask),
        .gate_len   (gate_len),
        .ch_sel     (ch_sel),
        .cnt_clr    (cnt_clr),
        .gate_en    (gate_en),
        .latch      (latch),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_ch     (res_ch),
        .busy       (busy),
        .cfg_err    (cfg_err)
    );

    function automatic logic [8:0] outs();
        return {ch_sel, cnt_clr, gate_en, latch, res_valid, res_ch, busy};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        step();
        abort = 1'b0;
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int gate_cnt, bad, bad2, bad3, bad4, n, seen;

        // cycle, ch_sel, cnt_clr, gate_en, latch, res_valid, res_ch, busy
        tbl[0]  = '{0,  2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0};
        tbl[1]  = '{1,  2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1};
        tbl[2]  = '{10, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1};
        tbl[3]  = '{11, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1};
        tbl[4]  = '{12, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1};
        tbl[5]  = '{31, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1};
        tbl[6]  = '{32, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1};
        tbl[7]  = '{33, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1};
        tbl[8]  = '{34, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1};
        tbl[9]  = '{44, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1};
        tbl[10] = '{45, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1};
        tbl[11] = '{64, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1};
        tbl[12] = '{65, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1};
        tbl[13] = '{66, 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1};
        tbl[14] = '{67, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0};

        rst = 1'b1; start = 1'b0; continuous = 1'b0; abort = 1'b0;
        res_ready = 1'b1; ch_mask = 4'b0000; gate_len = 32'd20;
        step(); step(); step();
        chk("reset_outputs", {23'd0, outs()}, 32'd0);
        chk("reset_cfg_err", {31'd0, cfg_err}, 32'd0);
        rst = 1'b0;
        step();

        // Basic single sweep over channels 0 and 2
        ch_mask = 4'b0101; gate_len = 32'd20; start = 1'b1;
        gate_cnt = 0;
        for (int c = 0; c <= 67; c++) begin
            for (int i = 0; i < NV; i++) begin
                if (tbl[i].cyc == c)
                    chk($sformatf("sweep_c%0d", c), {23'd0, outs()},
                        {23'd0, tbl[i].ch, tbl[i].clr, tbl[i].gate, tbl[i].lat,
                         tbl[i].vld, tbl[i].rch, tbl[i].bsy});
            end
            if (gate_en) gate_cnt++;
            step();
            start = 1'b0;
        end
        chk("sweep_gate_cycles", gate_cnt, 40);

        // Empty mask is rejected
        ch_mask = 4'b0000; start = 1'b1;
        step();
        start = 1'b0;
        chk("cfg_err_pulse", {30'd0, cfg_err, busy}, 32'b10);
        step();
        chk("cfg_err_drop", {31'd0, cfg_err}, 32'd0);
        bad = 0;
        for (int c = 0; c < 15; c++) begin
            if (busy || cnt_clr) bad = 1;
            step();
        end
        chk("cfg_err_idle", bad, 0);

        // Backpressure in REPORT
        ch_mask = 4'b0011; gate_len = 32'd3; res_ready = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        n = 0;
        while (!res_valid && n < 100) begin
            step();
            n++;
        end
        chk("bp_reach_report", {31'd0, res_valid}, 32'd1);
        bad = 0;
        for (int c = 0; c < 50; c++) begin
            if (!res_valid || res_ch != 2'd0 || gate_en || cnt_clr || latch) bad = 1;
            step();
        end
        chk("bp_hold_stable", bad, 0);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk("bp_next_settle", {23'd0, outs()}, {23'd0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1});
        for (int c = 0; c < 10; c++) step();
        chk("bp_next_clear", {31'd0, cnt_clr}, 32'd1);
        do_abort();
        res_ready = 1'b1;

        // Continuous, single channel, zero gate length; continuous input dropped mid-run
        ch_mask = 4'b1000; gate_len = 32'd0; continuous = 1'b1; start = 1'b1;
        bad = 0; bad2 = 0; bad3 = 0; bad4 = 0;
        for (int c = 0; c <= 44; c++) begin
            if (c >= 1) begin
                if (gate_en !== (c >= 12 && (c - 12) % 14 == 0)) bad = 1;
                if (res_valid !== (c >= 14 && (c - 14) % 14 == 0)) bad2 = 1;
                if (ch_sel != 2'd3 || (res_valid && res_ch != 2'd3)) bad3 = 1;
                if (!busy) bad4 = 1;
            end
            step();
            start = 1'b0;
            continuous = 1'b0;
        end
        chk("cont_gate_pattern", bad, 0);
        chk("cont_result_pattern", bad2, 0);
        chk("cont_channel", bad3, 0);
        chk("cont_busy", bad4, 0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("cont_abort", {29'd0, busy, gate_en, res_valid}, 32'd0);
        step();

        // Abort in the middle of a gate window, then a clean restart
        ch_mask = 4'b0001; gate_len = 32'd20; start = 1'b1;
        for (int c = 0; c < 16; c++) begin
            step();
            start = 1'b0;
        end
        chk("abort_in_gate", {31'd0, gate_en}, 32'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_drop", {29'd0, busy, gate_en, res_valid}, 32'd0);
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            if (latch || busy) seen = 1;
            step();
        end
        chk("abort_no_latch", seen, 0);
        start = 1'b1;
        for (int c = 0; c <= 34; c++) begin
            if (c == 32) chk("restart_latch", {30'd0, latch, res_valid}, 32'b10);
            if (c == 33) chk("restart_result", {29'd0, res_valid, res_ch}, 32'b100);
            if (c == 34) chk("restart_idle", {31'd0, busy}, 32'd0);
            step();
            start = 1'b0;
        end

        // Start ignored while busy; gate_len/continuous changes mid-sweep ignored
        ch_mask = 4'b0011; gate_len = 32'd5; continuous = 1'b0; start = 1'b1;
        gate_cnt = 0; seen = 0;
        for (int c = 0; c <= 37; c++) begin
            if (c == 5)  begin gate_len = 32'd9; ch_mask = 4'b0000; continuous = 1'b1; start = 1'b1; end
            if (c == 20) begin start = 1'b1; ch_mask = 4'b0100; end
            if (c == 20) chk("busy_ch_sel", {30'd0, ch_sel}, 32'd1);
            if (c == 36) chk("busy_result", {29'd0, res_valid, res_ch}, 32'b101);
            if (c == 37) chk("busy_end_idle", {31'd0, busy}, 32'd0);
            if (gate_en) gate_cnt++;
            if (cfg_err) seen = 1;
            step();
            start = 1'b0;
        end
        chk("busy_gate_cycles", gate_cnt, 10);
        chk("busy_no_cfg_err", seen, 0);

        // Synchronous reset in the middle of a gate window
        ch_mask = 4'b0011; gate_len = 32'd9; continuous = 1'b0; start = 1'b1;
        for (int c = 0; c < 14; c++) begin
            step();
            start = 1'b0;
        end
        chk("rst_pre_gate", {31'd0, gate_en}, 32'd1);
        rst = 1'b1;
        step();
        chk("rst_mid_gate", {22'd0, cfg_err, outs()}, 32'd0);
        rst = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
